// File: rtl/conv_fprop1_sdiv_32s_32s_32_seq.sv
// Iterative signed divider: one restoring shift/subtract step per enabled clock.
// Returns a quotient truncated toward zero and a remainder that carries the dividend's sign.
module conv_fprop1_sdiv_32s_32s_32_seq #(
    parameter int ID         = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quo,
    output logic [DATA_WIDTH-1:0] rem
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W:0]      r_q, r_d;
    logic [W:0]      d_q, d_d;
    logic            qsign_q, qsign_d;
    logic            rsign_q, rsign_d;
    logic            dz_q, dz_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rem_q, rem_d;
    logic            done_q, done_d;

    logic [W:0]      r_shift;
    logic [W:0]      r_sub;
    logic            q_bit;

    // a_q starts as |dividend| and is shifted out MSB-first while quotient bits shift in.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        r_d     = r_q;
        d_d     = d_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = 1'b0;

        r_shift = {r_q[W-1:0], a_q[W-1]};
        r_sub   = r_shift - d_q;
        q_bit   = (r_shift >= d_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = din0[W-1] ? (~din0 + 1'b1) : din0;
                    d_d     = {1'b0, (din1[W-1] ? (~din1 + 1'b1) : din1)};
                    r_d     = '0;
                    qsign_d = din0[W-1] ^ din1[W-1];
                    rsign_d = din0[W-1];
                    dz_d    = (din1 == '0);
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                r_d   = q_bit ? r_sub : r_shift;
                a_d   = {a_q[W-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // A zero divisor leaves r = |dividend|, so only the quotient needs forcing.
                quo_d   = dz_q ? '1 : (qsign_q ? (~a_q + 1'b1) : a_q);
                rem_d   = rsign_q ? (~r_q[W-1:0] + 1'b1) : r_q[W-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            r_q     <= r_d;
            d_q     <= d_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign quo   = quo_q;
    assign rem   = rem_q;

endmodule
